// File: rtl/mux16_sched_pkg.sv
// Shared definitions for the round-robin scheduler in front of mux16to1.
//   N_REQ         : number of requesters sharing the multiplexer
//   SEL_W         : width of the multiplexer select
//   sched_state_t : scheduler FSM states
//   onehot()      : select index to one-hot grant vector
package mux16_sched_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/mux16_rr_sched_rr_pick.sv
// rr_pick: combinational rotating priority encoder.
//   req   in  16 : request vector
//   ptr   in  4  : index with highest priority this round
//   found out 1  : at least one request is set
//   idx   out 4  : first set request scanning ptr, ptr+1, ... mod 16
module rr_pick
    import mux16_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             found,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block leaves it holding its old value
    // (which would infer a latch).
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            // Candidate index wraps naturally through the 4-bit addition.
            cand = ptr + SEL_W'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin scheduler driving the select of a shared
// 16:1 single-bit multiplexer. A grant is held until done, withdrawal of
// the granted request, or the hold timer expires; the fairness pointer
// then moves just past the released requester.
//   clk     in  1  : clock, rising edge
//   rst     in  1  : asynchronous active-high reset
//   req     in  16 : request vector
//   done    in  1  : consumer finished with the current grant
//   sel     out 4  : select for mux16to1 (index of granted requester)
//   grant   out 16 : one-hot grant while busy, else 0
//   busy    out 1  : grant active, sel valid
//   timeout out 1  : one-cycle pulse when the hold timer revokes a grant
module mux16_rr_sched
    import mux16_sched_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LAST =
        (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

    sched_state_t     state, state_n;
    logic [SEL_W-1:0] ptr, ptr_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [SEL_W-1:0] sel_n;
    logic [N_REQ-1:0] grant_n;
    logic             busy_n, timeout_n;

    logic             pick_found;
    logic [SEL_W-1:0] pick_idx;
    logic             hold_hit;

    rr_pick u_pick (
        .req   (req),
        .ptr   (ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hold_hit = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        sel_n     = sel;
        grant_n   = grant;
        busy_n    = busy;
        timeout_n = 1'b0;
        case (state)
            IDLE: begin
                grant_n = '0;
                busy_n  = 1'b0;
                if (pick_found) begin
                    sel_n   = pick_idx;
                    grant_n = onehot(pick_idx);
                    busy_n  = 1'b1;
                    hold_n  = '0;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (done || !req[sel] || hold_hit) begin
                    // Only a release caused purely by the timer is flagged.
                    timeout_n = !done && req[sel];
                    busy_n    = 1'b0;
                    grant_n   = '0;
                    ptr_n     = sel + 1'b1;
                    state_n   = IDLE;
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers see the values from before the edge, independent of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            sel      <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            hold_cnt <= hold_n;
            sel      <= sel_n;
            grant    <= grant_n;
            busy     <= busy_n;
            timeout  <= timeout_n;
        end
    end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Self-checking bench for mux16_rr_sched (MAX_HOLD = 8). Expected grant
// indices are queued when stimulus is applied and compared when busy rises.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mux16_rr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [3:0]  sel;
    logic [15:0] grant;
    logic        busy;
    logic        timeout;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_timeout = 0;
    logic        prev_busy = 1'b0;
    logic [3:0]  exp_q[$];

    mux16_rr_sched #(.MAX_HOLD(8), .HOLD_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .grant   (grant),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard side: compare each new grant against the queued expectation,
    // and check the grant/sel relationship every cycle.
    always @(negedge clk) begin
        if (busy) check("grant_onehot", grant, 32'(16'(1) << sel));
        else      check("grant_idle", grant, 0);
        if (timeout) n_timeout++;
        if (busy && !prev_busy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_grant", 32'(sel), 32'hFFFF);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                check("grant_sel", sel, e);
            end
        end
        prev_busy = busy;
    end

    // Waits for busy; returns the number of falling edges it took.
    task automatic wait_busy(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!busy && cycles < 50);
        if (!busy) check("busy_wait_timeout", 0, 1);
    endtask

    // Grant lasts two cycles, done is pulsed, and the busy gap is checked.
    task automatic grant_done(input string tag);
        int c;
        wait_busy(c);
        check({tag, "_latency"}, c, 1);
        @(negedge clk);
        check({tag, "_busy2"}, busy, 1);
        done = 1'b1;
        @(negedge clk);
        check({tag, "_released"}, busy, 0);
        check({tag, "_no_to"}, timeout, 0);
        done = 1'b0;
    endtask

    initial begin
        int c;
        int busy_len;
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        #2;
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_sel", sel, 0);
        check("rst_timeout", timeout, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_sel", sel, 0);
        end

        // Two requesters alternate: 0, 9, 0, 9.
        req = 16'h0201;
        exp_q.push_back(4'd0); exp_q.push_back(4'd9);
        exp_q.push_back(4'd0); exp_q.push_back(4'd9);
        for (int i = 0; i < 4; i++) grant_done("alt");
        req = 16'h0000;  // ptr now 10
        @(negedge clk);

        // Drive ptr to 15 via requester 14, then 15, then wrap to 0.
        req = 16'h4000; exp_q.push_back(4'd14); grant_done("r14");
        req = 16'h8000; exp_q.push_back(4'd15); grant_done("r15");
        req = 16'h0001; exp_q.push_back(4'd0);  grant_done("wrap0");
        req = 16'h0000;
        @(negedge clk);

        // Hold timeout: requester 4 held with done low.
        n_timeout = 0;
        req = 16'h0010;
        exp_q.push_back(4'd4); exp_q.push_back(4'd4);
        wait_busy(c);
        busy_len = 0;
        while (busy && busy_len < 20) begin
            busy_len++;
            @(negedge clk);
        end
        check("to_busy_len", busy_len, 8);
        check("to_pulse", timeout, 1);
        @(negedge clk);
        check("to_regrant", busy, 1);
        check("to_pulse_clear", timeout, 0);
        req = 16'h0000;  // withdraw: release without timeout
        @(negedge clk);
        check("to_withdraw_rel", busy, 0);
        check("to_withdraw_no_to", timeout, 0);
        check("to_pulse_count", n_timeout, 1);

        // Withdrawal of requester 3 on its second cycle.
        req = 16'h0008; exp_q.push_back(4'd3);
        wait_busy(c);
        @(negedge clk);
        req = 16'h0000;
        @(negedge clk);
        check("wd_released", busy, 0);
        check("wd_no_to", timeout, 0);

        // done coincides with the timeout cycle: no pulse.
        req = 16'h0008; exp_q.push_back(4'd3);
        n_timeout = 0;
        wait_busy(c);
        for (int i = 0; i < 7; i++) @(negedge clk);
        check("dt_still_busy", busy, 1);
        done = 1'b1;
        @(negedge clk);
        check("dt_released", busy, 0);
        check("dt_no_to", timeout, 0);
        done = 1'b0;
        req  = 16'h0000;
        @(negedge clk);
        check("dt_pulse_count", n_timeout, 0);

        // Asynchronous reset mid-grant of requester 7.
        req = 16'h0080; exp_q.push_back(4'd7);
        wait_busy(c);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_grant", grant, 0);
        check("arst_sel", sel, 0);
        @(negedge clk);
        rst = 1'b0;

        // Pointer back at 0: requester 0 wins before 7.
        req = 16'h0081;
        exp_q.push_back(4'd0); exp_q.push_back(4'd7);
        grant_done("post_rst0");
        grant_done("post_rst7");
        req = 16'h0000;
        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
